// File: rtl/fir_sym_par_if.sv
// Port bundle for fir_sym_par: sample stream, history flush, coefficient write port and result.
interface fir_sym_par_if #(
    parameter int DW = 12,
    parameter int CW = 12,
    parameter int AW = 3,
    parameter int YW = 28
);
    logic                 in_valid;
    logic signed [DW-1:0] xin;
    logic                 clear;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 out_valid;
    logic signed [YW-1:0] yout;

    modport master (
        output in_valid, xin, clear, coef_we, coef_addr, coef_wdata,
        input  out_valid, yout
    );

    modport slave (
        input  in_valid, xin, clear, coef_we, coef_addr, coef_wdata,
        output out_valid, yout
    );
endinterface

// File: rtl/fir_sym_par.sv
// Fully parallel symmetric (linear-phase) FIR with run-time loadable coefficients.
// Define FIR_ROUND_SAT_EN to add a round/shift/saturate output stage (yout becomes OUT_W wide).
module fir_sym_par #(
    parameter int DW     = 12,
    parameter int CW     = 12,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 16,
    parameter int RSHIFT = 8
) (
    input  logic         clk,
    input  logic         rst,
    fir_sym_par_if.slave bus
);
    localparam int HW    = TAPS / 2;
    localparam int AW    = (HW > 1) ? $clog2(HW) : 1;
    localparam int ACC_W = DW + CW + 1 + $clog2(HW);
    localparam int PW    = DW + 1;
    localparam int MW    = DW + CW + 1;
    localparam int FW    = $clog2(TAPS + 1);

    if ((TAPS % 2) != 0 || TAPS < 4) begin : g_bad_taps
        $error("fir_sym_par: TAPS must be even and >= 4");
    end
    if (OUT_W < 2 || RSHIFT < 0) begin : g_bad_out
        $error("fir_sym_par: OUT_W must be >= 2 and RSHIFT >= 0");
    end

    logic signed [DW-1:0]    x [TAPS];
    logic signed [PW-1:0]    p [HW];
    logic signed [MW-1:0]    m [HW];
    logic signed [CW-1:0]    c [HW];
    logic [FW-1:0]           fill;
    logic                    full;
    logic                    v0, v1, v2;
    logic signed [ACC_W-1:0] sum;

    // The line holds TAPS real samples after this shift when the count was already TAPS-1 or TAPS
    assign full = (fill == FW'(TAPS - 1)) || (fill == FW'(TAPS));

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            fill <= '0;
            v0   <= 1'b0;
        end else begin
            v0 <= bus.in_valid && full;
            if (bus.in_valid) begin
                x[0] <= bus.xin;
                for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                if (fill != FW'(TAPS)) fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int k = 0; k < HW; k++) begin
                p[k] <= '0;
                m[k] <= '0;
            end
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            for (int k = 0; k < HW; k++) begin
                p[k] <= PW'(x[k]) + PW'(x[TAPS-1-k]);
                m[k] <= MW'(p[k]) * MW'(c[k]);
            end
            v1 <= v0;
            v2 <= v1;
        end
    end

    // Addresses past the last unique coefficient are dropped silently
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < HW; k++) c[k] <= '0;
        end else if (bus.coef_we && ({1'b0, bus.coef_addr} < (AW + 1)'(HW))) begin
            c[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < HW; k++) sum = sum + ACC_W'(m[k]);
    end

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND  = (ACC_W + 1)'((longint'(1) << RSHIFT) >> 1);
    localparam logic signed [ACC_W:0] YMAX = (ACC_W + 1)'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] YMIN = (ACC_W + 1)'(-(longint'(1) << (OUT_W - 1)));

    logic signed [ACC_W-1:0] acc;
    logic                    v3;
    logic signed [ACC_W:0]   rounded;
    logic signed [OUT_W-1:0] sat;

    always_comb begin
        rounded = ((ACC_W + 1)'(acc) + RND) >>> RSHIFT;
        if (rounded > YMAX) begin
            sat = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (rounded < YMIN) begin
            sat = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            sat = OUT_W'(rounded);
        end
    end

    // The sum and output stages ignore clear so a result already past S2 still completes
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            v3            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.yout      <= '0;
        end else begin
            v3 <= v2;
            if (v2) acc <= sum;
            bus.out_valid <= v3;
            if (v3) bus.yout <= sat;
        end
    end
`else
    // The output stage ignores clear so a result already past S2 still completes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.yout      <= '0;
        end else begin
            bus.out_valid <= v2;
            if (v2) bus.yout <= sum;
        end
    end
`endif
endmodule
